// File: rtl/online_r4_pkg.sv
// Shared types and defaults for the radix-4 online adder sequencer.
package online_r4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int N_DEF     = 6;
    localparam int C_DEF     = 3;
    localparam int DELAY_DEF = 2;

    // The step counter must hold 0..N+DELAY-1 without wrapping.
    function automatic int cnt_width(input int n, input int delay);
        return $clog2(n + delay + 1);
    endfunction

endpackage

// File: rtl/online_digit_shifter.sv
// Parallel-load, MSD-first digit shift register; zeros enter from the LSD end for flushing.
module online_digit_shifter #(
    parameter int N = 6,
    parameter int C = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           shift_i,
    input  logic [N*C-1:0] din_i,
    output logic [C-1:0]   digit_o
);

    logic [N*C-1:0] sh_q;
    logic [N*C-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = din_i;
        end else if (shift_i) begin
            sh_d = sh_q << C;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign digit_o = sh_q[N*C-1 -: C];

endmodule

// File: rtl/online_adder_seq_r4.sv
// Sequencer feeding an online radix-4 adder MSD-first and assembling its N+1-digit result.
// Optional result checker (expected/pass/err_count) is built when ADDER_SEQ_CHECK_EN is defined.
module online_adder_seq_r4
    import online_r4_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int C     = C_DEF,
    parameter int DELAY = DELAY_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N*C-1:0]     x,
    input  logic [N*C-1:0]     y,
    output logic               busy,
    output logic               done,
    output logic [(N+1)*C-1:0] result,
    output logic               adder_reset,
    output logic               adder_en,
    output logic [C-1:0]       xi,
    output logic [C-1:0]       yi,
    input  logic [C-1:0]       zi
`ifdef ADDER_SEQ_CHECK_EN
    ,
    input  logic [(N+1)*C-1:0] expected,
    output logic               pass,
    output logic [7:0]         err_count
`endif
);

    localparam int KW   = cnt_width(N, DELAY);
    localparam int LAST = N + DELAY - 1;

    seq_state_t         state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [(N+1)*C-1:0] result_q, result_d;
    logic               busy_q, done_q, en_q;
    logic [C-1:0]       xi_q, yi_q;
    logic               accept;
    logic               feed;
    logic [C-1:0]       x_digit, y_digit;
    logic [N:0]         cap_en;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    // Shifters advance exactly when a digit is handed to the adder for the next RUN cycle.
    assign feed   = (state_d == RUN);

    online_digit_shifter #(.N(N), .C(C)) u_shift_x (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (feed),
        .din_i   (x),
        .digit_o (x_digit)
    );

    online_digit_shifter #(.N(N), .C(C)) u_shift_y (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (feed),
        .din_i   (y),
        .digit_o (y_digit)
    );

    // Result digit gi is produced by the adder at RUN step N+DELAY-1-gi.
    for (genvar gi = 0; gi <= N; gi++) begin : g_cap
        assign cap_en[gi] = (state_q == RUN) && (k_q == KW'(LAST - gi));
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = CLEAR;
                    k_d      = '0;
                    result_d = '0;
                end
            end
            CLEAR: begin
                state_d = RUN;
                k_d     = '0;
            end
            RUN: begin
                if (k_q == KW'(LAST)) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (accept) begin
                    state_d  = CLEAR;
                    k_d      = '0;
                    result_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        for (int i = 0; i <= N; i++) begin
            if (cap_en[i]) begin
                result_d[i*C +: C] = zi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            xi_q     <= '0;
            yi_q     <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            result_q <= result_d;
            busy_q   <= (state_d == CLEAR) || (state_d == RUN);
            done_q   <= (state_d == DONE);
            en_q     <= feed;
            xi_q     <= feed ? x_digit : '0;
            yi_q     <= feed ? y_digit : '0;
        end
    end

    assign adder_reset = reset | (state_q == CLEAR);
    assign busy        = busy_q;
    assign done        = done_q;
    assign adder_en    = en_q;
    assign xi          = xi_q;
    assign yi          = yi_q;
    assign result      = result_q;

`ifdef ADDER_SEQ_CHECK_EN
    logic       pass_q;
    logic [7:0] err_q;

    // The error tally survives across runs and only a reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_q <= 1'b0;
            err_q  <= '0;
        end else if (state_q == DONE) begin
            pass_q <= (result_q == expected);
            if ((result_q != expected) && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign pass      = pass_q;
    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_online_adder_seq_r4.sv
// Bench for online_adder_seq_r4: a behavioural online adder drives zi, results are checked against x+y.
module tb_online_adder_seq_r4;

    localparam int N      = 6;
    localparam int C      = 3;
    localparam int DELAY  = 2;
    localparam int NW     = N * C;
    localparam int RW     = (N + 1) * C;
    localparam int RUNLEN = N + DELAY;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NW-1:0] x, y;
    logic          busy, done;
    logic [RW-1:0] result;
    logic          adder_reset, adder_en;
    logic [C-1:0]  xi, yi, zi;
`ifdef ADDER_SEQ_CHECK_EN
    logic [RW-1:0] expected = '0;
    logic          pass;
    logic [7:0]    err_count;
`endif

    int checks = 0;
    int errors = 0;

    online_adder_seq_r4 #(.N(N), .C(C), .DELAY(DELAY)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .adder_reset (adder_reset),
        .adder_en    (adder_en),
        .xi          (xi),
        .yi          (yi),
        .zi          (zi)
`ifdef ADDER_SEQ_CHECK_EN
        ,
        .expected    (expected),
        .pass        (pass),
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural online adder: keeps the exact unemitted residual and emits the rounded
    // leading digit once two input pairs have been seen (online delay 2).
    int res_m = 0;
    int cnt_m = 0;
    int zq[$];
    int tin;
    int dm;

    function automatic int fdiv16(input int a);
        int q;
        q = a / 16;
        if ((a % 16) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    assign tin = int'($signed(xi)) + int'($signed(yi));
    assign dm  = fdiv16(4 * res_m + tin + 8);
    assign zi  = (cnt_m != 0) ? 3'(dm) : 3'(0);

    always @(posedge clk) begin
        if (adder_reset) begin
            res_m <= 0;
            cnt_m <= 0;
            zq.delete();
        end else if (adder_en) begin
            if (cnt_m == 0) begin
                res_m <= tin;
            end else begin
                res_m <= 4 * res_m + tin - 16 * dm;
                zq.push_back(dm);
            end
            cnt_m <= cnt_m + 1;
        end
    end

    function automatic longint dval(input logic [RW-1:0] v, input int nd);
        longint acc;
        logic [C-1:0] dg;
        acc = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            dg  = v[i*C +: C];
            acc = acc * 4 + longint'($signed(dg));
        end
        return acc;
    endfunction

    function automatic logic [RW-1:0] pack_zq();
        logic [RW-1:0] b;
        b = '0;
        for (int i = 0; i <= N; i++) b[(N-i)*C +: C] = 3'(zq[i]);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction starting in the current cycle (cycle 0); ends inside the DONE cycle.
    task automatic run_one(input logic [NW-1:0] xv, input logic [NW-1:0] yv,
                           input int poke, input bit exp_ok);
        longint ev;
        x = xv;
        y = yv;
        start = 1'b1;
        for (int j = 1; j <= RUNLEN + 2; j++) begin
            tick();
            if (j == 1) start = 1'b0;
            if (j == poke) start = 1'b1;
            if (j == poke + 1) start = 1'b0;
            x = NW'($urandom);
            y = NW'($urandom);
            if (j == 1) chk("result_clear", 64'(result), 64'(0));
            chk("busy", 64'(busy), 64'(j <= RUNLEN + 1));
            chk("adder_reset", 64'(adder_reset), 64'(j == 1));
            chk("adder_en", 64'(adder_en), 64'(j >= 2 && j <= RUNLEN + 1));
            chk("done", 64'(done), 64'(j == RUNLEN + 2));
        end
        ev = dval(RW'(xv), N) + dval(RW'(yv), N);
        chk("result_value", 64'(dval(result, N + 1)), 64'(ev));
        chk("digit_count", 64'(zq.size()), 64'(N + 1));
        if (zq.size() == N + 1) chk("result_digits", 64'(result), 64'(pack_zq()));
`ifdef ADDER_SEQ_CHECK_EN
        expected = exp_ok ? pack_zq() : ~pack_zq();
`endif
        $display("run x=%o y=%o result=%o value=%0d ref=%0d", xv, yv, result, dval(result, N + 1), ev);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_xi", 64'(xi), 64'(0));
        chk("rst_yi", 64'(yi), 64'(0));
        chk("rst_adder_en", 64'(adder_en), 64'(0));
        chk("rst_adder_reset", 64'(adder_reset), 64'(1));
        reset = 1'b0;
        tick();
        chk("idle_adder_reset", 64'(adder_reset), 64'(0));

        // Basic sum of all +1 digits
        run_one(18'o111111, 18'o111111, -1, 1'b1);
        chk("sum_2730", 64'(dval(result, N + 1)), 64'(2730));
        tick();
        chk("done_pulse", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("hold_result", 64'(dval(result, N + 1)), 64'(2730));
        tick();
        chk("hold_result2", 64'(dval(result, N + 1)), 64'(2730));

        // Negative digits cancel
        run_one(18'o777777, 18'o111111, -1, 1'b1);
        chk("sum_zero", 64'(dval(result, N + 1)), 64'(0));
        tick();

        // Start pulse while busy must be ignored
        run_one(18'o111111, 18'o111111, 4, 1'b1);
        chk("ignored_start", 64'(dval(result, N + 1)), 64'(2730));
        tick();

        // Back-to-back: second start held across DONE
        run_one(18'o111111, 18'o111111, -1, 1'b1);
        run_one(18'o300000, 18'o111111, -1, 1'b1);
        chk("b2b_sum", 64'(dval(result, N + 1)), 64'(3 * 1024 + 1365));
        tick();

        // Extreme digits
        run_one(18'o444444, 18'o444444, -1, 1'b1);
        tick();
        run_one(18'o333333, 18'o333333, -1, 1'b1);
        tick();

        // Abort with reset in the middle of RUN
        x = 18'o123456;
        y = 18'o654321;
        start = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("abort_adder_reset", 64'(adder_reset), 64'(1));
        tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_result", 64'(result), 64'(0));
        chk("abort_adder_en", 64'(adder_en), 64'(0));
        chk("abort_adder_reset_off", 64'(adder_reset), 64'(0));
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'(0));
        end
        run_one(18'o123456, 18'o654321, -1, 1'b1);
        tick();

        // Randomized operands
        for (int r = 0; r < 24; r++) begin
            run_one(NW'($urandom), NW'($urandom), -1, 1'b1);
            if (r % 3 != 0) tick();
        end
        tick();

`ifdef ADDER_SEQ_CHECK_EN
        run_one(NW'($urandom), NW'($urandom), -1, 1'b1);
        tick();
        chk("pass_ok", 64'(pass), 64'(1));
        chk("err_zero", 64'(err_count), 64'(0));
        run_one(NW'($urandom), NW'($urandom), -1, 1'b0);
        tick();
        chk("pass_bad", 64'(pass), 64'(0));
        chk("err_one", 64'(err_count), 64'(1));
        for (int r = 0; r < 300; r++) begin
            run_one(NW'($urandom), NW'($urandom), -1, 1'b0);
            tick();
        end
        chk("err_saturate", 64'(err_count), 64'(255));
        chk("pass_still_bad", 64'(pass), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
